// File: rtl/lmfe_med49_ctrl.sv
// Raster-scan sequencer for a 7x7 running-median engine: primes the window at the
// start of each row, then slides it one column at a time and hands out one median per pixel.
`timescale 1ns/1ps
module lmfe_med49_ctrl #(
  parameter int IMG_W   = 128,
  parameter int IMG_H   = 128,
  parameter int AW      = 14,
  parameter int PAD_VAL = 0
) (
  input  logic                      clk,
  input  logic                      RST_N,
  input  logic                      START,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      RD_A_EN,
  output logic [AW-1:0]             RD_A_ADDR,
  input  logic [7:0]                RD_A_DATA,
  output logic                      RD_B_EN,
  output logic [AW-1:0]             RD_B_ADDR,
  input  logic [7:0]                RD_B_DATA,
  output logic                      ENG_CLR,
  output logic                      ENG_SEN,
  output logic [7:0]                ENG_INS,
  output logic [7:0]                ENG_DEL,
  input  logic [7:0]                ENG_MED,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [7:0]                OUT_PIX,
  output logic [$clog2(IMG_W)-1:0]  OUT_X,
  output logic [$clog2(IMG_H)-1:0]  OUT_Y
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  // Two guard bits so x+3 cannot wrap back into the image even for tiny widths.
  localparam int CW = ((XW > YW) ? XW : YW) + 2;

  localparam logic signed [CW-1:0] Z_S = '0;
  localparam logic signed [CW-1:0] W_S = CW'(IMG_W);
  localparam logic signed [CW-1:0] H_S = CW'(IMG_H);
  localparam logic signed [CW-1:0] C3  = CW'(3);
  localparam logic signed [CW-1:0] C4  = CW'(4);
  localparam logic [XW-1:0]        X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0]        Y_LAST = YW'(IMG_H - 1);
  localparam logic [AW-1:0]        W_A    = AW'(IMG_W);
  localparam logic [7:0]           PAD8   = 8'(PAD_VAL);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_PRIME, S_SLIDE, S_WAIT, S_OUT
  } state_t;

  state_t         state_q, state_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic [2:0]     kc_q, kc_d;
  logic [2:0]     kr_q, kr_d;
  logic           pair_v_q, pair_v_d;
  logic           pad_a_q, pad_a_d;
  logic           pad_b_q, pad_b_d;
  logic           prime_q, prime_d;
  logic           eng_clr_q, eng_clr_d;
  logic           done_q, done_d;

  logic signed [CW-1:0] xs, ys, kcs, krs, ax, ay, bx;
  logic                 a_in, b_in;
  logic [AW-1:0]        a_addr, b_addr;
  logic                 rd_a_en, rd_b_en;

  // Window coordinates for the current read cycle; kc/kr are the prime column/row offsets.
  always_comb begin
    xs  = signed'(CW'(x_q));
    ys  = signed'(CW'(y_q));
    kcs = signed'(CW'(kc_q));
    krs = signed'(CW'(kr_q));
    ay  = ys + krs - C3;
    ax  = (state_q == S_PRIME) ? (xs + kcs - C3) : (xs + C3);
    bx  = xs - C4;
    a_in = (ax >= Z_S) && (ax < W_S) && (ay >= Z_S) && (ay < H_S);
    b_in = (bx >= Z_S) && (bx < W_S) && (ay >= Z_S) && (ay < H_S);
    a_addr = a_in ? (AW'(ay[YW-1:0]) * W_A + AW'(ax[XW-1:0])) : '0;
    b_addr = b_in ? (AW'(ay[YW-1:0]) * W_A + AW'(bx[XW-1:0])) : '0;
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    kc_d     = kc_q;
    kr_d     = kr_q;
    pair_v_d = 1'b0;
    pad_a_d  = 1'b0;
    pad_b_d  = 1'b0;
    prime_d  = 1'b0;
    done_d   = 1'b0;
    rd_a_en  = 1'b0;
    rd_b_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START && !done_q) begin
          state_d = S_CLR;
          x_d     = '0;
          y_d     = '0;
        end
      end
      S_CLR: begin
        state_d = S_PRIME;
        kc_d    = '0;
        kr_d    = '0;
      end
      S_PRIME: begin
        rd_a_en  = a_in;
        pair_v_d = 1'b1;
        pad_a_d  = !a_in;
        prime_d  = 1'b1;
        if (kr_q == 3'd6) begin
          kr_d = '0;
          kc_d = kc_q + 3'd1;
          if (kc_q == 3'd6) state_d = S_WAIT;
        end else begin
          kr_d = kr_q + 3'd1;
        end
      end
      S_SLIDE: begin
        rd_a_en  = a_in;
        rd_b_en  = b_in;
        pair_v_d = 1'b1;
        pad_a_d  = !a_in;
        pad_b_d  = !b_in;
        if (kr_q == 3'd6) begin
          kr_d    = '0;
          state_d = S_WAIT;
        end else begin
          kr_d = kr_q + 3'd1;
        end
      end
      S_WAIT: state_d = S_OUT;
      S_OUT: begin
        if (OUT_READY) begin
          if (x_q != X_LAST) begin
            x_d     = x_q + XW'(1);
            kr_d    = '0;
            state_d = S_SLIDE;
          end else if (y_q != Y_LAST) begin
            x_d     = '0;
            y_d     = y_q + YW'(1);
            state_d = S_CLR;
          end else begin
            x_d     = '0;
            y_d     = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    eng_clr_d = (state_d == S_CLR);
  end

  // Engine clear resets high so an aborted frame leaves the engine flushed.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      kc_q      <= '0;
      kr_q      <= '0;
      pair_v_q  <= 1'b0;
      pad_a_q   <= 1'b0;
      pad_b_q   <= 1'b0;
      prime_q   <= 1'b0;
      eng_clr_q <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      kc_q      <= kc_d;
      kr_q      <= kr_d;
      pair_v_q  <= pair_v_d;
      pad_a_q   <= pad_a_d;
      pad_b_q   <= pad_b_d;
      prime_q   <= prime_d;
      eng_clr_q <= eng_clr_d;
      done_q    <= done_d;
    end
  end

  assign BUSY      = (state_q != S_IDLE);
  assign DONE      = done_q;
  assign RD_A_EN   = rd_a_en;
  assign RD_B_EN   = rd_b_en;
  assign RD_A_ADDR = rd_a_en ? a_addr : '0;
  assign RD_B_ADDR = rd_b_en ? b_addr : '0;
  assign ENG_CLR   = eng_clr_q;
  assign ENG_SEN   = !pair_v_q;
  assign ENG_INS   = !pair_v_q ? 8'd0 : (pad_a_q ? PAD8 : RD_A_DATA);
  assign ENG_DEL   = !pair_v_q ? 8'd0 :
                     (prime_q ? 8'hFF : (pad_b_q ? PAD8 : RD_B_DATA));
  assign OUT_VALID = (state_q == S_OUT);
  assign OUT_PIX   = OUT_VALID ? ENG_MED : 8'd0;
  assign OUT_X     = OUT_VALID ? x_q : '0;
  assign OUT_Y     = OUT_VALID ? y_q : '0;

endmodule

// File: tb/tb_lmfe_med49_ctrl.sv
// Bench for lmfe_med49_ctrl on an 8x8 image: behavioural RAM and 49-entry engine,
// expected medians from a direct 7x7 zero-padded window computation.
`timescale 1ns/1ps
module tb_lmfe_med49_ctrl;
  localparam int W = 8;
  localparam int H = 8;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic RST_N = 1'b1;
  logic START = 1'b0;
  logic OUT_READY = 1'b1;
  logic BUSY, DONE, RD_A_EN, RD_B_EN, ENG_CLR, ENG_SEN, OUT_VALID;
  logic [AW-1:0] RD_A_ADDR, RD_B_ADDR;
  logic [7:0] rdAData = 8'd0;
  logic [7:0] rdBData = 8'd0;
  logic [7:0] engMed = 8'd255;
  logic [7:0] ENG_INS, ENG_DEL, OUT_PIX;
  logic [2:0] OUT_X, OUT_Y;

  typedef struct { int pix; int x; int y; } exp_t;
  exp_t expQ[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int doneCnt = 0;
  int hsCnt = 0;
  int refCyc = 0;
  int refGap = 0;
  bit refArmed = 1'b0;
  logic [7:0] mem [0:W*H-1];
  int got [0:H-1][0:W-1];

  lmfe_med49_ctrl #(.IMG_W(W), .IMG_H(H), .AW(AW), .PAD_VAL(0)) dut (
    .clk(clk), .RST_N(RST_N), .START(START), .BUSY(BUSY), .DONE(DONE),
    .RD_A_EN(RD_A_EN), .RD_A_ADDR(RD_A_ADDR), .RD_A_DATA(rdAData),
    .RD_B_EN(RD_B_EN), .RD_B_ADDR(RD_B_ADDR), .RD_B_DATA(rdBData),
    .ENG_CLR(ENG_CLR), .ENG_SEN(ENG_SEN), .ENG_INS(ENG_INS), .ENG_DEL(ENG_DEL),
    .ENG_MED(engMed), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_PIX(OUT_PIX), .OUT_X(OUT_X), .OUT_Y(OUT_Y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Two-port synchronous RAM: requests captured mid-cycle, data returned after the edge.
  initial begin : ramModel
    logic aEn, bEn;
    logic [AW-1:0] aAd, bAd;
    forever begin
      @(negedge clk);
      aEn = RD_A_EN; aAd = RD_A_ADDR; bEn = RD_B_EN; bAd = RD_B_ADDR;
      @(posedge clk);
      if (aEn) rdAData = mem[aAd];
      if (bEn) rdBData = mem[bAd];
    end
  end

  // Running-median engine kept as a value histogram of the 49 window entries.
  initial begin : engModel
    int hist [0:255];
    int acc;
    logic clr, sen;
    logic [7:0] ins, del;
    forever begin
      @(negedge clk);
      clr = ENG_CLR; sen = ENG_SEN; ins = ENG_INS; del = ENG_DEL;
      @(posedge clk);
      if (clr) begin
        for (int v = 0; v < 256; v++) hist[v] = 0;
        hist[255] = 49;
        engMed = 8'd255;
      end else if (!sen) begin
        hist[ins] = hist[ins] + 1;
        hist[del] = hist[del] - 1;
        acc = 0;
        for (int v = 0; v < 256; v++) begin
          acc = acc + hist[v];
          if (acc > 24) begin
            engMed = 8'(v);
            break;
          end
        end
      end
    end
  end

  function automatic int expMed(input int cx, input int cy);
    int h [0:255];
    int acc, px, xx, yy;
    for (int v = 0; v < 256; v++) h[v] = 0;
    for (int dy = -3; dy <= 3; dy++) begin
      for (int dx = -3; dx <= 3; dx++) begin
        xx = cx + dx; yy = cy + dy;
        px = (xx >= 0 && xx < W && yy >= 0 && yy < H) ? int'(mem[yy*W + xx]) : 0;
        h[px] = h[px] + 1;
      end
    end
    acc = 0;
    for (int v = 0; v < 256; v++) begin
      acc = acc + h[v];
      if (acc > 24) return v;
    end
    return 255;
  endfunction

  task automatic checkOutput(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  // Scoreboard consumer: pops on every handshake and checks output spacing.
  initial begin : monitor
    exp_t e;
    bit prevV;
    prevV = 1'b0;
    forever begin
      @(negedge clk);
      if (DONE) doneCnt++;
      if (OUT_VALID && !prevV && refArmed) begin
        checkOutput("out_latency", cyc - refCyc, refGap);
        refArmed = 1'b0;
      end
      if (OUT_VALID && OUT_READY) begin
        hsCnt++;
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_out: got x=%0d y=%0d pix=%0d, expected no output",
                   OUT_X, OUT_Y, OUT_PIX);
        end else begin
          e = expQ.pop_front();
          checkOutput($sformatf("pix(%0d,%0d)", e.x, e.y), int'(OUT_PIX), e.pix);
          checkOutput($sformatf("outx(%0d,%0d)", e.x, e.y), int'(OUT_X), e.x);
          checkOutput($sformatf("outy(%0d,%0d)", e.x, e.y), int'(OUT_Y), e.y);
          got[e.y][e.x] = int'(OUT_PIX);
          refCyc = cyc;
          refGap = (e.x == W-1) ? 52 : 9;
          refArmed = !(e.x == W-1 && e.y == H-1);
        end
      end
      prevV = OUT_VALID;
    end
  end

  task automatic loadImage(input int kind);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        case (kind)
          0:       mem[y*W + x] = 8'd100;
          1:       mem[y*W + x] = 8'(x);
          default: mem[y*W + x] = 8'($urandom_range(0, 255));
        endcase
  endtask

  task automatic applyStimulus(input int kind);
    exp_t e;
    loadImage(kind);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        e.pix = expMed(x, y); e.x = x; e.y = y;
        expQ.push_back(e);
      end
    hsCnt = 0;
    doneCnt = 0;
    @(posedge clk); #1;
    START = 1'b1;
    refCyc = cyc; refGap = 52; refArmed = 1'b1;
    @(posedge clk); #1;
    START = 1'b0;
  endtask

  task automatic pulseStart();
    @(posedge clk); #1 START = 1'b1;
    @(posedge clk); #1 START = 1'b0;
  endtask

  task automatic waitPix(input int x, input int y);
    bit found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clk);
      if (OUT_VALID && int'(OUT_X) == x && int'(OUT_Y) == y) found = 1'b1;
    end
    if (!found) timeoutFail($sformatf("wait_pix(%0d,%0d)", x, y));
  endtask

  task automatic waitValid();
    bit found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (OUT_VALID) found = 1'b1;
    end
    if (!found) timeoutFail("wait_valid");
  endtask

  task automatic waitDone();
    bit found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clk);
      if (doneCnt > 0) found = 1'b1;
    end
    if (!found) timeoutFail("wait_done");
    repeat (3) @(negedge clk);
  endtask

  task automatic checkIdle(input string p);
    checkOutput({p, "_eng_clr"}, int'(ENG_CLR), 1);
    checkOutput({p, "_eng_sen"}, int'(ENG_SEN), 1);
    checkOutput({p, "_busy"}, int'(BUSY), 0);
    checkOutput({p, "_done"}, int'(DONE), 0);
    checkOutput({p, "_out_valid"}, int'(OUT_VALID), 0);
    checkOutput({p, "_rd_a_en"}, int'(RD_A_EN), 0);
    checkOutput({p, "_rd_b_en"}, int'(RD_B_EN), 0);
    checkOutput({p, "_rd_a_addr"}, int'(RD_A_ADDR), 0);
    checkOutput({p, "_eng_ins"}, int'(ENG_INS), 0);
    checkOutput({p, "_eng_del"}, int'(ENG_DEL), 0);
    checkOutput({p, "_out_pix"}, int'(OUT_PIX), 0);
  endtask

  initial begin : stimulus
    int bad;
    int busySeen;
    int stallPix;
    #3 RST_N = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkIdle("reset");
    @(posedge clk); #1 RST_N = 1'b1;

    $display("[TB] constant image");
    applyStimulus(0);
    waitDone();
    checkOutput("c100_x3y3", got[3][3], 100);
    checkOutput("c100_x4y4", got[4][4], 100);
    checkOutput("c100_x0y0", got[0][0], 0);
    checkOutput("c100_x0y3", got[3][0], 100);
    checkOutput("c100_handshakes", hsCnt, 64);
    checkOutput("c100_dones", doneCnt, 1);

    $display("[TB] ramp image with stray START pulses");
    applyStimulus(1);
    repeat (20) @(posedge clk);
    pulseStart();
    waitPix(3, 2);
    pulseStart();
    waitPix(7, 7);
    @(posedge clk); #1 START = 1'b1;
    @(negedge clk);
    checkOutput("done_pulse", int'(DONE), 1);
    checkOutput("busy_at_done", int'(BUSY), 0);
    @(posedge clk); #1 START = 1'b0;
    busySeen = 0;
    repeat (80) begin
      @(negedge clk);
      busySeen = busySeen | int'(BUSY);
    end
    checkOutput("no_restart", busySeen, 0);
    checkOutput("ramp_x4y4", got[4][4], 4);
    checkOutput("ramp_handshakes", hsCnt, 64);
    checkOutput("ramp_dones", doneCnt, 1);

    $display("[TB] random image with backpressure at (2,5)");
    applyStimulus(2);
    waitPix(1, 5);
    @(posedge clk); #1 OUT_READY = 1'b0;
    waitValid();
    stallPix = expMed(2, 5);
    bad = 0;
    repeat (20) begin
      if (!OUT_VALID || int'(OUT_X) != 2 || int'(OUT_Y) != 5 || int'(OUT_PIX) != stallPix ||
          !ENG_SEN || RD_A_EN || RD_B_EN) bad++;
      @(negedge clk);
    end
    checkOutput("stall_stable_cycles_bad", bad, 0);
    @(posedge clk); #1 OUT_READY = 1'b1;
    waitDone();
    checkOutput("rand_handshakes", hsCnt, 64);
    checkOutput("rand_dones", doneCnt, 1);

    $display("[TB] reset during row 4");
    applyStimulus(3);
    waitPix(2, 4);
    @(posedge clk);
    @(posedge clk); #1 RST_N = 1'b0;
    @(negedge clk);
    checkIdle("abort");
    @(posedge clk); #1 RST_N = 1'b1;
    expQ.delete();
    refArmed = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("abort_no_done", doneCnt, 0);
    checkOutput("abort_stays_idle", int'(BUSY), 0);
    applyStimulus(3);
    waitDone();
    checkOutput("rerun_handshakes", hsCnt, 64);
    checkOutput("rerun_dones", doneCnt, 1);
    checkOutput("rerun_queue_empty", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
